count_sched: RTL and testbench

COUNT_SCHED -- requirements
Module: count_sched

---
 rtl/count_sched.sv | 159 +++++++++++++++
 tb/tb_count_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/count_sched.sv
// ---------------------------------------------------------------------------
// count_sched -- two-requester round-robin scheduler for one shared counter.
//
// The winning requester owns an N-bit counter that runs from 0 up to the
// terminal count latched from its len input at grant time. It then finishes
// with a one-cycle done pulse followed by a one-cycle DONE state. If the owner
// drops req early, it gets a one-cycle abort pulse instead.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   req[1:0] in   per-requester request, held until done/abort
//   len0/1   in   N-bit terminal count, sampled only at grant
//   pause    in   optional, only when COUNT_SCHED_PAUSE_EN is defined;
//                 freezes the count in RUN
//   gnt[1:0] out  one-hot owner, or zero
//   Q        out  shared counter value
//   busy     out  high in RUN and DONE
//   done     out  one-cycle completion pulse
//   done_id  out  finished requester index while done=1, else 0
//   abort    out  one-cycle pulse when the owner drops req mid-count
//
// Configuration macro: COUNT_SCHED_PAUSE_EN (adds the pause input).
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module count_sched #(
   parameter int N = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [1:0]   req,
   input  logic [N-1:0] len0,
   input  logic [N-1:0] len1,
`ifdef COUNT_SCHED_PAUSE_EN
   input  logic         pause,
`endif
   output logic [1:0]   gnt,
   output logic [N-1:0] Q,
   output logic         busy,
   output logic         done,
   output logic         done_id,
   output logic         abort
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t       state_q, state_d;
   logic [1:0]   gnt_q, gnt_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] term_q, term_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         done_id_q, done_id_d;
   logic         abort_q, abort_d;
   logic         last_q, last_d;   // index of the requester served last

   logic         pause_w;
   logic         win;              // arbitration winner index
   logic         own;              // current owner index (valid in RUN)

`ifdef COUNT_SCHED_PAUSE_EN
   assign pause_w = pause;
`else
   assign pause_w = 1'b0;
`endif

   // On a tie, the requester that was not served last wins.
   // Otherwise the only active requester wins.
   assign win = (req == 2'b11) ? ~last_q : req[1];
   assign own = gnt_q[1];

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      term_d    = term_q;
      busy_d    = busy_q;
      last_d    = last_q;
      done_d    = 1'b0;
      done_id_d = 1'b0;
      abort_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_d = S_RUN;
               gnt_d   = win ? 2'b10 : 2'b01;
               cnt_d   = '0;
               term_d  = win ? len1 : len0;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            // An owner drop takes precedence over both pause and completion.
            if (!req[own]) begin
               state_d = S_IDLE;
               gnt_d   = 2'b00;
               cnt_d   = '0;
               busy_d  = 1'b0;
               abort_d = 1'b1;
               last_d  = own;
            end else if (pause_w) begin
               state_d = S_RUN;
            end else if (cnt_q == term_q) begin
               // Q keeps the terminal value through DONE.
               state_d   = S_DONE;
               gnt_d     = 2'b00;
               done_d    = 1'b1;
               done_id_d = own;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            // Requests are deliberately not sampled here, so the next
            // grant comes no earlier than the following IDLE cycle.
            state_d = S_IDLE;
            busy_d  = 1'b0;
            last_d  = done_id_q;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         gnt_q     <= 2'b00;
         cnt_q     <= '0;
         term_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         abort_q   <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         term_q    <= term_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         abort_q   <= abort_d;
         last_q    <= last_d;
      end
   end

   assign gnt     = gnt_q;
   assign Q       = cnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign abort   = abort_q;

endmodule

// File: tb/tb_count_sched.sv
// ---------------------------------------------------------------------------
// tb_count_sched -- directed bench for count_sched.
//
// A transaction-level model (owner index, elapsed count, cool-down flag)
// predicts every output. It is checked on each falling edge. The directed
// sequence also pins hand-computed literal values at key cycles.
// ---------------------------------------------------------------------------
module tb_count_sched;
   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [1:0]   req = 2'b00;
   logic [N-1:0] len0 = '0;
   logic [N-1:0] len1 = '0;
   logic         pause = 1'b0;
   logic [1:0]   gnt;
   logic [N-1:0] Q;
   logic         busy, done, done_id, abort;

   int checks = 0;
   int failures = 0;

   count_sched #(.N(N)) dut (
      .CLK(CLK), .RST(RST), .req(req), .len0(len0), .len1(len1),
`ifdef COUNT_SCHED_PAUSE_EN
      .pause(pause),
`endif
      .gnt(gnt), .Q(Q), .busy(busy), .done(done), .done_id(done_id),
      .abort(abort)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit started = 0;
   int m_owner = -1;   // -1: nobody owns the counter
   int m_q = 0;
   int m_term = 0;
   int m_last = 1;
   bit m_cool = 0;     // the single cycle following a completed count
   int m_fin = 0;      // requester that just finished
   bit m_done = 0;
   bit m_abort = 0;

   always @(posedge CLK) begin
      if (RST) begin
         started = 1; m_owner = -1; m_q = 0; m_term = 0; m_last = 1;
         m_cool = 0; m_fin = 0; m_done = 0; m_abort = 0;
      end else begin
         m_done = 0; m_abort = 0;
         if (m_cool) begin
            m_cool = 0;
            m_last = m_fin;
         end else if (m_owner < 0) begin
            if (req != 0) begin
               if (req == 2'b11) m_owner = (m_last == 1) ? 0 : 1;
               else              m_owner = req[1] ? 1 : 0;
               m_q = 0;
               m_term = (m_owner == 1) ? int'(len1) : int'(len0);
            end
         end else if (!req[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_q = 0; m_abort = 1;
         end else if (pause) begin
            m_q = m_q;
         end else if (m_q == m_term) begin
            m_fin = m_owner; m_owner = -1; m_done = 1; m_cool = 1;
         end else begin
            m_q = (m_q + 1) % (1 << N);
         end
      end
   end

   always @(negedge CLK) begin
      if (started) begin
         chk("m_gnt", 32'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
         chk("m_Q", 32'(Q), m_q);
         chk("m_busy", 32'(busy), 32'((m_owner >= 0) || m_cool));
         chk("m_done", 32'(done), 32'(m_done));
         chk("m_done_id", 32'(done_id), m_done ? m_fin : 0);
         chk("m_abort", 32'(abort), 32'(m_abort));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   initial begin
      // reset
      step(2);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_Q", 32'(Q), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_abort", 32'(abort), 0);
      RST = 0;

      // single requester, len0=3; len0 changes after grant are ignored
      req = 2'b01; len0 = 4'd3;
      step(); chk("t1_gnt", 32'(gnt), 32'h1); chk("t1_Q0", 32'(Q), 0);
      len0 = 4'd9;
      step(3); chk("t1_Q3", 32'(Q), 3);
      step(); chk("t1_done", 32'(done), 1); chk("t1_id", 32'(done_id), 0);
      chk("t1_gnt_off", 32'(gnt), 0);
      req = 2'b00;
      step(); chk("t1_busy_off", 32'(busy), 0);

      // both request from reset: requester 0 first, then 1
      RST = 1; step(); RST = 0;
      req = 2'b11; len0 = 4'd1; len1 = 4'd2;
      step(); chk("t2_gnt0", 32'(gnt), 32'h1);
      step(2); chk("t2_done0", 32'(done), 1); chk("t2_id0", 32'(done_id), 0);
      req = 2'b10;
      step(); chk("t2_done_cyc_gnt", 32'(gnt), 0);
      step(); chk("t2_gnt1", 32'(gnt), 32'h2); chk("t2_Q0", 32'(Q), 0);
      step(2); chk("t2_Q2", 32'(Q), 2);
      step(); chk("t2_done1", 32'(done), 1); chk("t2_id1", 32'(done_id), 1);
      req = 2'b00; step();

      // term = 0: a single RUN cycle
      req = 2'b01; len0 = 4'd0;
      step(); chk("t3_gnt", 32'(gnt), 32'h1); chk("t3_Q", 32'(Q), 0);
      step(); chk("t3_done", 32'(done), 1);
      req = 2'b00; step();

      // owner drops at Q=2 of a len0=5 count
      req = 2'b01; len0 = 4'd5;
      step(3); chk("t4_Q2", 32'(Q), 2);
      req = 2'b00;
      step(); chk("t4_abort", 32'(abort), 1); chk("t4_gnt", 32'(gnt), 0);
      chk("t4_done", 32'(done), 0);
      step(); chk("t4_abort_clr", 32'(abort), 0);

      // after the abort of 0, a tie goes to 1; req0 held throughout is not lost
      req = 2'b11; len0 = 4'd0; len1 = 4'd0;
      step(); chk("t5_gnt1", 32'(gnt), 32'h2);
      step(); chk("t5_id1", 32'(done_id), 1);
      req = 2'b01;
      step(2); chk("t5_gnt0", 32'(gnt), 32'h1);
      step(); chk("t5_id0", 32'(done), 1);
      req = 2'b00; step();

      // reset mid-RUN
      req = 2'b01; len0 = 4'd5;
      step(2); chk("t6_Q1", 32'(Q), 1);
      RST = 1;
      step(); chk("t6_gnt", 32'(gnt), 0); chk("t6_Q", 32'(Q), 0);
      chk("t6_busy", 32'(busy), 0);
      RST = 0; req = 2'b00;
      step(); chk("t6_done", 32'(done), 0); chk("t6_abort", 32'(abort), 0);

      // full-range terminal count: reaches all ones without wrapping
      req = 2'b01; len0 = 4'd15;
      step(16); chk("t7_Q15", 32'(Q), 15);
      step(); chk("t7_done", 32'(done), 1); chk("t7_Qhold", 32'(Q), 15);
      req = 2'b00; step(2);

`ifdef COUNT_SCHED_PAUSE_EN
      // pause for 3 cycles at Q=2 delays done by exactly 3 cycles
      req = 2'b01; len0 = 4'd4;
      step(3); chk("t8_Q2", 32'(Q), 2);
      pause = 1'b1;
      step(3); chk("t8_hold", 32'(Q), 2); chk("t8_nodone", 32'(done), 0);
      pause = 1'b0;
      step(2); chk("t8_Q4", 32'(Q), 4);
      step(); chk("t8_done", 32'(done), 1);
      req = 2'b00; step(2);
`endif

      @(negedge CLK); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
